// File: rtl/div_unit_pkg.sv
// Shared types and sizing for the iterative signed divider.
package div_unit_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    function automatic int div_cnt_w(input int w);
        return $clog2(w);
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring shift-subtract iteration on magnitudes.
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]        shifted;
    logic signed [WIDTH:0] trial;

    // rem < dvs always holds, so the shifted remainder needs one extra bit and
    // the difference fits in WIDTH+1 signed bits.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial    = $signed(shifted - {1'b0, dvs});
    assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed divider (MIPS div): quotient on lo, remainder on hi.
// Optional `DIV_UNIT_DIVU_EN adds is_unsigned for MIPS divu.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNIT_DIVU_EN
    input  logic             is_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = div_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_quo;
    logic             neg_rem;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    logic                    uns;
    logic signed [WIDTH-1:0] dividend_s;
    logic signed [WIDTH-1:0] divisor_s;
    logic                    sign_a;
    logic                    sign_b;

`ifdef DIV_UNIT_DIVU_EN
    assign uns = is_unsigned;
`else
    assign uns = 1'b0;
`endif

    assign dividend_s = $signed(dividend);
    assign divisor_s  = $signed(divisor);
    assign sign_a     = (dividend_s < 0) && !uns;
    assign sign_b     = (divisor_s < 0) && !uns;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvs      (dvs),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            done    <= 1'b1;
                            divzero <= 1'b1;
                        end else begin
                            // Magnitudes wrap modulo 2^WIDTH, so -2^(W-1) stays 0x80..0.
                            neg_quo <= sign_a ^ sign_b;
                            neg_rem <= sign_a;
                            quo     <= cond_neg(dividend, sign_a);
                            dvs     <= cond_neg(divisor, sign_b);
                            rem     <= '0;
                            cnt     <= '0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= cond_neg(quo, neg_quo);
                    hi    <= cond_neg(rem, neg_rem);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a cycle-level reference model and literal pins.
module tb_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         divzero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef DIV_UNIT_DIVU_EN
    logic         is_unsigned;
`endif

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_UNIT_DIVU_EN
        .is_unsigned (is_unsigned),
`endif
        .busy        (busy),
        .done        (done),
        .divzero     (divzero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: MIPS div semantics via 64-bit arithmetic, result after WIDTH+1 edges.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dz   = 1'b0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;
    int           m_cnt  = 0;

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = W'(sa / sb);
        r  = W'(sa % sb);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_hi = '0; m_lo = '0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_lo = p_lo; m_hi = p_hi; m_done = 1'b1; m_busy = 1'b0;
                end
            end else if (start) begin
                if (divisor == '0) begin
                    m_done = 1'b1; m_dz = 1'b1;
                end else begin
                    ref_div(dividend, divisor, p_lo, p_hi);
                    m_busy = 1'b1;
                    m_cnt  = W + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_busy", W'(busy), W'(m_busy));
        check("model_done", W'(done), W'(m_done));
        check("model_divzero", W'(divzero), W'(m_dz));
        check("model_hi", hi, m_hi);
        check("model_lo", lo, m_lo);
    end

    // Pulse start for one edge; returns right after that sampling edge (+1).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
        int n;
        launch(a, b);
        wait_done(n);
        check({name, "_latency"}, W'(n), W'(33));
        check({name, "_lo"}, lo, exp_lo);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_divzero"}, W'(divzero), '0);
    endtask

    initial begin
        int n;
        int done_seen;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV_UNIT_DIVU_EN
        is_unsigned = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_div("pos_7_2", 32'd7, 32'd2, 32'd3, 32'd1);
        run_div("neg_7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("7_neg2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("min_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("neg1_min", 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
        run_div("max_1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0);
        run_div("neg100_neg7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);

        // Start accepted in the same cycle done is high.
        launch(32'd20, 32'd6);
        wait_done(n);
        check("b2b_first_lo", lo, 32'd3);
        launch(32'd100, 32'd7);
        wait_done(n);
        check("b2b_latency", W'(n), W'(33));
        check("b2b_lo", lo, 32'd14);
        check("b2b_hi", hi, 32'd2);

        // Divide by zero keeps previous hi/lo.
        launch(32'd5, 32'd0);
        check("dz_done", W'(done), W'(1));
        check("dz_flag", W'(divzero), W'(1));
        check("dz_busy", W'(busy), '0);
        check("dz_hi", hi, 32'd2);
        check("dz_lo", lo, 32'd14);
        @(posedge clk); #1;
        check("dz_done_pulse", W'(done), '0);

        // Start while busy is ignored; operand changes after capture are ignored.
        launch(32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        launch(32'd9, 32'd3);
        dividend = 32'd1234;
        divisor  = 32'd5;
        n = 3;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        check("ignore_latency", W'(n), W'(33));
        check("ignore_lo", lo, 32'd14);
        check("ignore_hi", hi, 32'd2);

        // Asynchronous reset mid-run aborts without a done.
        launch(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", W'(busy), '0);
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("abort_no_done", W'(done_seen), '0);
        run_div("after_abort", 32'd9, 32'd3, 32'd3, 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
